// File: rtl/mwadd_pkg.sv
// mwadd_pkg: sequencer state encoding and chunk-index width helper
// Optional feature macro: MWADD_SUB_EN (used by multiword_add_seq).
package mwadd_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_e;
  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction
endpackage

// File: rtl/cascade_adder.sv
// cascade_adder: combinational SIZE-bit ripple-carry adder
// Ports: a, b operands; c carry-in; s sum; k carry-out.
module cascade_adder #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            c,
  output logic [SIZE-1:0] s,
  output logic            k
);
  logic [SIZE:0] cy;
  assign cy[0] = c;
  for (genvar i = 0; i < SIZE; i++) begin : g_fa
    assign s[i]    = a[i] ^ b[i] ^ cy[i];
    assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
  end
  assign k = cy[SIZE];
endmodule

// File: rtl/multiword_add_seq.sv
// multiword_add_seq: WORDS*SIZE-bit add performed one SIZE-bit chunk per cycle on a shared adder
// Ports: clk, rst (sync, active-high); start/a_in/b_in/cin (and sub) sampled on accept in IDLE;
//        busy from the cycle after accept through DONE; done one-cycle pulse; sum/cout result registers.
// Optional feature macro: MWADD_SUB_EN adds the sub port (A - B - cin, cout=1 means no borrow).
module multiword_add_seq
  import mwadd_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORDS*SIZE-1:0] a_in,
  input  logic [WORDS*SIZE-1:0] b_in,
  input  logic                  cin,
`ifdef MWADD_SUB_EN
  input  logic                  sub,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [WORDS*SIZE-1:0] sum,
  output logic                  cout
);
  localparam int W  = WORDS * SIZE;
  localparam int IW = idx_w(WORDS);
  state_e        state_q, state_d;
  logic [W-1:0]  a_q, b_q, sum_q, b_load;
  logic [IW-1:0] idx_q;
  logic          carry_q, cout_q, c_load, last, accept, k;
  logic [SIZE-1:0] s;
`ifdef MWADD_SUB_EN
  // Subtraction as A + ~B + ~cin through the same adder.
  assign b_load = sub ? ~b_in : b_in;
  assign c_load = sub ? ~cin : cin;
`else
  assign b_load = b_in;
  assign c_load = cin;
`endif
  assign last   = idx_q == IW'(WORDS - 1);
  assign accept = (state_q == ST_IDLE) && start;
  cascade_adder #(.SIZE(SIZE)) u_add (
    .a(a_q[idx_q*SIZE +: SIZE]),
    .b(b_q[idx_q*SIZE +: SIZE]),
    .c(carry_q),
    .s(s),
    .k(k)
  );
  // The unused encoding 2'd3 falls through to IDLE.
  always_comb begin
    state_d = (state_q == ST_IDLE) ? (start ? ST_RUN : ST_IDLE) :
              (state_q == ST_RUN)  ? (last ? ST_DONE : ST_RUN) : ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= a_in;
        b_q     <= b_load;
        carry_q <= c_load;
        idx_q   <= '0;
      end else if (state_q == ST_RUN) begin
        sum_q[idx_q*SIZE +: SIZE] <= s;
        carry_q <= k;
        idx_q   <= idx_q + 1'b1;
        if (last) cout_q <= k;
      end
    end
  end
  assign busy = state_q != ST_IDLE;
  assign done = state_q == ST_DONE;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_multiword_add_seq.sv
// tb_multiword_add_seq: directed and random checks of multiword_add_seq against an arithmetic model
module tb_multiword_add_seq;
  logic        clk = 1'b0;
  logic        rst, start, cin, sub;
  logic [15:0] a_in, b_in, sum;
  logic        busy, done, cout;
  int          checks = 0;
  int          errors = 0;

  multiword_add_seq #(.SIZE(4), .WORDS(4)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a_in(a_in),
    .b_in(b_in),
    .cin(cin),
`ifdef MWADD_SUB_EN
    .sub(sub),
`endif
    .busy(busy),
    .done(done),
    .sum(sum),
    .cout(cout)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] model(input logic [15:0] a, b, input logic ci, s);
    return s ? ({1'b0, a} + {1'b0, ~b} + 17'(~ci)) : ({1'b0, a} + {1'b0, b} + 17'(ci));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge; start is accepted at the next rising edge.
  task automatic op(input logic [15:0] a, b, input logic ci, s, input int hold);
    logic [16:0] exp;
    int k;
    exp = model(a, b, ci, s);
    a_in = a; b_in = b; cin = ci; sub = s; start = 1'b1;
    @(negedge clk);
    k = 1;
    while (!done && k < 20) begin
      chk("busy_run", busy, 1);
      if (k <= hold) begin
        a_in = 16'($urandom);
        b_in = 16'($urandom);
      end else start = 1'b0;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk("latency", k, 5);
    chk("done", done, 1);
    chk("busy_done", busy, 1);
    chk("sum", sum, exp[15:0]);
    chk("cout", cout, exp[16]);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
    chk("sum_hold", sum, exp[15:0]);
    chk("cout_hold", cout, exp[16]);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cin = 1'b0; sub = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    rst = 1'b0;
    @(negedge clk);
    op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    chk("t1_sum", sum, 16'h5555);
    op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    chk("t2_cout", cout, 1);
    op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
    op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 0);
    chk("t3_sum", sum, 16'h1000);
    op(16'h0001, 16'h0001, 1'b0, 1'b0, 3);
    chk("t4_sum", sum, 16'h0002);
    a_in = 16'h00AA; b_in = 16'h0055; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    op(16'h8421, 16'h1248, 1'b1, 1'b0, 0);
    for (int i = 0; i < 30; i++) begin
`ifdef MWADD_SUB_EN
      op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0);
`else
      op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 0);
`endif
    end
`ifdef MWADD_SUB_EN
    op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    chk("t6_sum_a", sum, 16'hFFFE);
    chk("t6_cout_a", cout, 0);
    op(16'h0007, 16'h0005, 1'b0, 1'b1, 0);
    chk("t6_sum_b", sum, 16'h0002);
    chk("t6_cout_b", cout, 1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
